// File: rtl/seq_bit_serializer_if.sv
// rtl/seq_bit_serializer_if.sv - parallel word handshake into the bit serializer
interface seq_bit_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - word-to-bit serializer with one-entry hold register
module seq_bit_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_bit_serializer_if.slave  word_bus,
  output logic                 out_bit,
  output logic                 bit_valid,
  output logic                 frame_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     words_sent
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  // Bit that leaves the word first, and the word with that bit consumed.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign word_bus.data_ready = !hold_full;
  assign accept              = word_bus.data_valid && !hold_full;
  assign busy                = (state == SHIFT) || hold_full;

  // The shifter reloads when idle or on the final bit; the hold word has priority.
  always_comb begin
    load_en   = 1'b0;
    load_word = word_bus.data_in;
    if (state == IDLE) begin
      load_en = accept;
    end else if (frame_last) begin
      if (hold_full) begin
        load_en   = 1'b1;
        load_word = hold_reg;
      end else begin
        load_en = accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      idx        <= '0;
      out_bit    <= IDLE_BIT;
      bit_valid  <= 1'b0;
      frame_last <= 1'b0;
      words_sent <= '0;
    end else begin
      if (load_en) begin
        state      <= SHIFT;
        shreg      <= advance(load_word);
        idx        <= '0;
        out_bit    <= head(load_word);
        bit_valid  <= 1'b1;
        frame_last <= 1'b0;
      end else if (state == SHIFT && !frame_last) begin
        shreg      <= advance(shreg);
        idx        <= idx + IDX_W'(1);
        out_bit    <= head(shreg);
        frame_last <= (idx == PRE_LAST);
      end else begin
        state      <= IDLE;
        idx        <= '0;
        out_bit    <= IDLE_BIT;
        bit_valid  <= 1'b0;
        frame_last <= 1'b0;
      end

      if (state == SHIFT && frame_last) begin
        words_sent <= words_sent + CNT_W'(1);
      end

      // Hold fills mid-word and drains into the shifter on the final bit.
      if (accept && state == SHIFT && !frame_last) begin
        hold_reg  <= word_bus.data_in;
        hold_full <= 1'b1;
      end else if (hold_full && frame_last) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
